// File: rtl/input_conditioner_pkg.sv
// Shared helpers and constants for the input conditioner: width math,
// millisecond prescaler derivation and per-channel reset levels.
package input_conditioner_pkg;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((64'd1 << result) < 64'(value)) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Clock cycles per millisecond tick.
   function automatic int tick_div(input int clkspeed);
      return clkspeed / 1000;
   endfunction

   // Prescaler counter width; at least one bit even when tick_div is 1.
   function automatic int tick_width(input int clkspeed);
      int w;
      w = clog2(tick_div(clkspeed));
      return (w < 1) ? 1 : w;
   endfunction

   // Synchroniser reset levels, expressed after any pin inversion.
   // The select channel resetting to 0 corresponds to a released (high) pin.
   localparam logic SW_INACTIVE  = 1'b0;
   localparam logic SEL_INACTIVE = 1'b0;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One conditioned input: two-flop synchroniser followed by a tick-qualified
// stability counter. A new level is accepted only after DEBOUNCE_MS
// consecutive ticks all see it differing from the current stable level.
module debounce_bit
   import input_conditioner_pkg::*;
#(
   parameter int   DEBOUNCE_MS = 10,
   parameter logic INVERT      = 1'b0,
   parameter logic INACTIVE    = 1'b0
) (
   input  logic clk,
   input  logic reset_b,
   input  logic tick,
   input  logic raw,
   output logic stable
);

   localparam int CNT_W = clog2(DEBOUNCE_MS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

   logic             sync_1;
   logic             s;
   logic [CNT_W-1:0] cnt;

   // Bring the asynchronous pin into the clk domain (inversion applied first).
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         sync_1 <= INACTIVE;
         s      <= INACTIVE;
      end else begin
         sync_1 <= raw ^ INVERT;
         s      <= sync_1;
      end
   end

   // Qualify: any cycle where s agrees with stable restarts the count.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (s == stable) begin
         cnt <= '0;
      end else if (tick) begin
         if (cnt == CNT_LAST) begin
            stable <= s;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces the switch bank and the active-low select
// button, and produces single-cycle press / change strobes.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int CLKSPEED    = 50000000,
   parameter int DEBOUNCE_MS = 10,
   parameter int NUM_SW      = 8
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic [NUM_SW-1:0] sw,
   input  logic              select,
   output logic [NUM_SW-1:0] sw_db,
   output logic              select_db,
   output logic              select_press,
   output logic              sw_changed
);

   localparam int TICK_DIV = tick_div(CLKSPEED);
   localparam int TICK_W   = tick_width(CLKSPEED);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic [NUM_SW:0]   stable;
   logic [NUM_SW:0]   prev;

   assign tick = (tick_cnt == TICK_LAST);

   // Millisecond prescaler shared by every channel.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      debounce_bit #(
         .DEBOUNCE_MS (DEBOUNCE_MS),
         .INVERT      (1'b0),
         .INACTIVE    (SW_INACTIVE)
      ) u_db (
         .clk     (clk),
         .reset_b (reset_b),
         .tick    (tick),
         .raw     (sw[i]),
         .stable  (stable[i])
      );
   end

   // The button pin is active-low; invert so the channel is active-high.
   debounce_bit #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .INVERT      (1'b1),
      .INACTIVE    (SEL_INACTIVE)
   ) u_sel_db (
      .clk     (clk),
      .reset_b (reset_b),
      .tick    (tick),
      .raw     (select),
      .stable  (stable[NUM_SW])
   );

   assign sw_db     = stable[NUM_SW-1:0];
   assign select_db = stable[NUM_SW];

   // Registered edge detect: strobes fire the cycle after a level commits.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         prev         <= '0;
         select_press <= 1'b0;
         sw_changed   <= 1'b0;
      end else begin
         prev         <= stable;
         select_press <= stable[NUM_SW] & ~prev[NUM_SW];
         sw_changed   <= |(stable[NUM_SW-1:0] ^ prev[NUM_SW-1:0]);
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: table vectors, hand-written corner cases and
// randomized stimulus, all checked against a cycle-level reference model.
module tb_input_conditioner;

   localparam int CLKSPEED    = 10000;
   localparam int DEBOUNCE_MS = 3;
   localparam int NUM_SW      = 8;
   localparam int TICK_DIV    = CLKSPEED / 1000;
   localparam int LAT_MIN     = (DEBOUNCE_MS - 1) * TICK_DIV + 3;
   localparam int LAT_MAX     = DEBOUNCE_MS * TICK_DIV + 3;

   logic              clk;
   logic              reset_b;
   logic [NUM_SW-1:0] sw;
   logic              select;
   logic [NUM_SW-1:0] sw_db;
   logic              select_db;
   logic              select_press;
   logic              sw_changed;

   int passed = 0;
   int total  = 0;
   int n_press = 0;
   int n_chg   = 0;

   input_conditioner #(
      .CLKSPEED    (CLKSPEED),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .NUM_SW      (NUM_SW)
   ) dut (
      .clk          (clk),
      .reset_b      (reset_b),
      .sw           (sw),
      .select       (select),
      .sw_db        (sw_db),
      .select_db    (select_db),
      .select_press (select_press),
      .sw_changed   (sw_changed)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      total++;
      if (act >= lo && act <= hi) passed++;
      else $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
   endtask

   // ---------------- reference model ----------------
   // Conditioned pin values per edge since reset release; the value used at
   // edge n is the one sampled at edge n-2. Ticks fall on edges where
   // n mod TICK_DIV == TICK_DIV-1.
   logic [NUM_SW:0] pin_q[$];
   logic [NUM_SW:0] m_st, m_st_d1;
   int              m_run[NUM_SW+1];
   int              m_n;
   logic            exp_press, exp_chg;

   task automatic model_step();
      logic [NUM_SW:0] old_st, s, nxt;
      bit tk;
      if (!reset_b) begin
         m_st = '0; m_st_d1 = '0; m_n = 0;
         exp_press = 1'b0; exp_chg = 1'b0;
         pin_q.delete();
         for (int i = 0; i <= NUM_SW; i++) m_run[i] = 0;
         return;
      end
      old_st    = m_st;
      exp_press = old_st[NUM_SW] & ~m_st_d1[NUM_SW];
      exp_chg   = (old_st[NUM_SW-1:0] != m_st_d1[NUM_SW-1:0]);
      tk        = (m_n % TICK_DIV) == (TICK_DIV - 1);
      pin_q.push_back({~select, sw});
      s = (pin_q.size() >= 3) ? pin_q[pin_q.size()-3] : '0;
      if (pin_q.size() > 3) void'(pin_q.pop_front());
      nxt = old_st;
      for (int ch = 0; ch <= NUM_SW; ch++) begin
         if (s[ch] == old_st[ch]) m_run[ch] = 0;
         else if (tk) begin
            if (m_run[ch] == DEBOUNCE_MS - 1) begin
               nxt[ch] = s[ch];
               m_run[ch] = 0;
            end else m_run[ch]++;
         end
      end
      m_st_d1 = old_st;
      m_st    = nxt;
      m_n++;
   endtask

   // Advance the model on each edge and compare every output shortly after.
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #2;
         check("model", {21'd0, sw_db, select_db, select_press, sw_changed},
                        {21'd0, m_st[NUM_SW-1:0], m_st[NUM_SW], exp_press, exp_chg});
         if (select_press) n_press++;
         if (sw_changed) n_chg++;
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic [NUM_SW-1:0] sw;
      logic              sel_pin;
      logic [NUM_SW-1:0] exp_sw;
      logic              exp_sel;
   } vec_t;

   vec_t vecs[7];

   task automatic cycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Count edges until sw_db matches value (bounded).
   task automatic wait_sw(input logic [NUM_SW-1:0] v, output int lat);
      lat = 0;
      while (sw_db !== v && lat < LAT_MAX + 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic wait_sel(input logic v, output int lat);
      lat = 0;
      while (select_db !== v && lat < LAT_MAX + 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, p0, c0;
      bit seen;
      logic [NUM_SW-1:0] first_val;

      vecs[0] = '{8'h00, 1'b1, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
      vecs[2] = '{8'h0F, 1'b0, 8'h0F, 1'b1};
      vecs[3] = '{8'hF0, 1'b0, 8'hF0, 1'b1};
      vecs[4] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
      vecs[5] = '{8'h5A, 1'b0, 8'h5A, 1'b1};
      vecs[6] = '{8'h00, 1'b1, 8'h00, 1'b0};

      // Reset with inputs already active.
      reset_b = 1'b0; sw = 8'hFF; select = 1'b0;
      cycles(5);
      check("reset_outs", {sw_db, select_db, select_press, sw_changed}, 32'd0);
      p0 = n_press; c0 = n_chg;
      reset_b = 1'b1;
      wait_sw(8'hFF, lat);
      check_range("reset_release_lat", lat, LAT_MIN, LAT_MAX);
      check("reset_sel_db", select_db, 1'b1);
      cycles(5);
      check("reset_chg_pulses", n_chg - c0, 1);
      check("reset_press_pulses", n_press - p0, 1);

      // Table vectors.
      for (int i = 0; i < 7; i++) begin
         sw = vecs[i].sw; select = vecs[i].sel_pin;
         cycles(40);
         check("vec_sw_db", sw_db, vecs[i].exp_sw);
         check("vec_sel_db", select_db, vecs[i].exp_sel);
      end

      // Clean press and release.
      p0 = n_press;
      select = 1'b0;
      wait_sel(1'b1, lat);
      check_range("press_lat", lat, LAT_MIN, LAT_MAX);
      cycles(100 - lat);
      check("press_pulses", n_press - p0, 1);
      p0 = n_press;
      select = 1'b1;
      wait_sel(1'b0, lat);
      check_range("release_lat", lat, LAT_MIN, LAT_MAX);
      cycles(10);
      check("release_pulses", n_press - p0, 0);

      // Bounce rejection on sw[3].
      c0 = n_chg;
      for (int i = 0; i < 14; i++) begin
         sw[3] = ~sw[3];
         cycles(15);
         check("bounce_hold", sw_db[3], 1'b0);
      end
      sw[3] = 1'b1;
      wait_sw(8'h08, lat);
      check_range("bounce_settle_lat", lat, LAT_MIN, LAT_MAX);
      cycles(5);
      check("bounce_chg_pulses", n_chg - c0, 1);
      sw = 8'h00;
      cycles(40);

      // Simultaneous commit.
      c0 = n_chg;
      sw = 8'hA5;
      lat = 0;
      while (sw_db === 8'h00 && lat < LAT_MAX + 20) begin
         @(negedge clk);
         lat++;
      end
      first_val = sw_db;
      check("simul_first_value", first_val, 8'hA5);
      cycles(5);
      check("simul_chg_pulses", n_chg - c0, 1);
      sw = 8'h00;
      cycles(40);

      // Short glitch on select.
      p0 = n_press; seen = 0;
      select = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (select_db) seen = 1;
      end
      select = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (select_db) seen = 1;
      end
      check("glitch_sel_db", seen, 1'b0);
      check("glitch_press", n_press - p0, 0);

      // Reset in the middle of a qualification.
      sw[0] = 1'b1;
      cycles(15);
      reset_b = 1'b0;
      #1;
      check("midreset_sw_db", sw_db, 8'h00);
      @(negedge clk);
      reset_b = 1'b1;
      wait_sw(8'h01, lat);
      check_range("midreset_requal_lat", lat, LAT_MIN, LAT_MAX);
      cycles(5);

      // Randomized stimulus against the model.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            reset_b = 1'b0;
            @(negedge clk);
            reset_b = 1'b1;
         end
         if ($urandom_range(0, 1) == 0) sw = NUM_SW'($urandom);
         else sw[$urandom_range(0, NUM_SW-1)] ^= 1'b1;
         select = 1'($urandom);
         cycles($urandom_range(1, 40));
      end
      cycles(5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
